// File: rtl/radar_pkg.sv
// Shared defaults, derived widths and FSM encodings for the radar sync receiver.
package radar_pkg;

    parameter int unsigned DEF_ACP_PER_REV = 4096;
    parameter int unsigned DEF_RANGE_BINS  = 1024;
    parameter int unsigned DEF_CLK_PER_BIN = 4;

    parameter int unsigned DEF_AZ_W  = $clog2(DEF_ACP_PER_REV);
    parameter int unsigned DEF_BIN_W = $clog2(DEF_RANGE_BINS);
    parameter int unsigned DEF_DIV_W = $clog2(DEF_CLK_PER_BIN);

    // Azimuth lock: leaves StUnlocked on the first ARP, only reset returns it.
    typedef enum logic [0:0] {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

    // Range sweep sequencer.
    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } range_state_e;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for an asynchronous pin.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic det
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       det_q;
    // Fills with ones after reset; detection stays masked until prev_q holds a real
    // sample, so a pin already high at reset release never looks like an edge.
    logic [2:0] prime_q;

    // Synchronize, remember the previous level and register the edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            det_q   <= 1'b0;
            prime_q <= 3'b000;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            prime_q <= {prime_q[1:0], 1'b1};
            det_q   <= sync_q & ~prev_q & prime_q[2];
        end
    end

    assign det = det_q;

endmodule

// File: rtl/radar_sync_rx.sv
// Radar timing receiver: azimuth tracking from ARP/ACP and range-bin strobes from trig.
module radar_sync_rx
    import radar_pkg::*;
#(
    parameter int unsigned ACP_PER_REV = DEF_ACP_PER_REV,
    parameter int unsigned RANGE_BINS  = DEF_RANGE_BINS,
    parameter int unsigned CLK_PER_BIN = DEF_CLK_PER_BIN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arp,
    input  logic                           acp,
    input  logic                           trig,
    output logic [$clog2(ACP_PER_REV)-1:0] azimuth,
    output logic                           az_valid,
    output logic [$clog2(ACP_PER_REV)-1:0] sweep_azimuth,
    output logic [$clog2(RANGE_BINS)-1:0]  range_bin,
    output logic                           bin_strobe,
    output logic                           sweep_active,
    output logic                           acp_err,
    output logic                           trig_overrun
);

    localparam int unsigned AW = $clog2(ACP_PER_REV);
    localparam int unsigned RW = $clog2(RANGE_BINS);
    localparam int unsigned DW = $clog2(CLK_PER_BIN);

    logic arp_det;
    logic acp_det;
    logic trig_det;

    pulse_sync u_arp_sync  (.clk(clk), .rst(rst), .din(arp),  .det(arp_det));
    pulse_sync u_acp_sync  (.clk(clk), .rst(rst), .din(acp),  .det(acp_det));
    pulse_sync u_trig_sync (.clk(clk), .rst(rst), .din(trig), .det(trig_det));

    logic [AW-1:0] az_q;
    logic [AW:0]   acp_cnt_q;
    logic          acp_err_q;
    lock_state_e   lock_q;
    lock_state_e   lock_d;

    // Azimuth counter (ARP wins over a coincident ACP) and saturating ACPs-since-ARP count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            az_q      <= '0;
            acp_cnt_q <= '0;
            acp_err_q <= 1'b0;
        end else begin
            acp_err_q <= (lock_q == StLocked) && arp_det &&
                         (acp_cnt_q != (AW+1)'(ACP_PER_REV));
            if (arp_det) begin
                az_q      <= '0;
                acp_cnt_q <= '0;
            end else if (acp_det) begin
                az_q <= az_q + 1'b1;
                if (acp_cnt_q != '1) begin
                    acp_cnt_q <= acp_cnt_q + 1'b1;
                end
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= StUnlocked;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock next state: any ARP locks, nothing but reset unlocks.
    always_comb begin
        lock_d = lock_q;
        if (arp_det) begin
            lock_d = StLocked;
        end
    end

    range_state_e  rng_q;
    range_state_e  rng_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [RW-1:0] bin_q;
    logic [RW-1:0] bin_d;
    logic [AW-1:0] sweep_az_q;
    logic [AW-1:0] sweep_az_d;
    logic          overrun_q;
    logic          overrun_d;
    logic          strobe;

    // Range sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rng_q      <= StIdle;
            div_q      <= '0;
            bin_q      <= '0;
            sweep_az_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rng_q      <= rng_d;
            div_q      <= div_d;
            bin_q      <= bin_d;
            sweep_az_q <= sweep_az_d;
            overrun_q  <= overrun_d;
        end
    end

    // Range next state: trig (re)starts a sweep; the divider paces one strobe per bin.
    always_comb begin
        rng_d      = rng_q;
        div_d      = div_q;
        bin_d      = bin_q;
        sweep_az_d = sweep_az_q;
        overrun_d  = 1'b0;
        strobe     = (rng_q == StSweep) && (div_q == DW'(CLK_PER_BIN - 1));
        case (rng_q)
            StIdle: begin
                if (trig_det) begin
                    rng_d      = StSweep;
                    div_d      = '0;
                    bin_d      = '0;
                    sweep_az_d = az_q;
                end
            end
            StSweep: begin
                // A trig here, including in the final strobe cycle, is an overrun restart.
                if (trig_det) begin
                    overrun_d  = 1'b1;
                    div_d      = '0;
                    bin_d      = '0;
                    sweep_az_d = az_q;
                end else if (strobe) begin
                    div_d = '0;
                    if (bin_q == RW'(RANGE_BINS - 1)) begin
                        rng_d = StIdle;
                        bin_d = '0;
                    end else begin
                        bin_d = bin_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: rng_d = StIdle;
        endcase
    end

    assign azimuth       = az_q;
    assign az_valid      = (lock_q == StLocked);
    assign sweep_azimuth = sweep_az_q;
    assign range_bin     = bin_q;
    assign bin_strobe    = strobe;
    assign sweep_active  = (rng_q == StSweep);
    assign acp_err       = acp_err_q;
    assign trig_overrun  = overrun_q;

endmodule

// File: tb/tb_radar_sync_rx.sv
// Scoreboard bench for radar_sync_rx with a small event-level reference model.
module tb_radar_sync_rx;

    localparam int ACP  = 16;
    localparam int BINS = 8;
    localparam int CPB  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       arp;
    logic       acp;
    logic       trig;
    logic [3:0] azimuth;
    logic       az_valid;
    logic [3:0] sweep_azimuth;
    logic [2:0] range_bin;
    logic       bin_strobe;
    logic       sweep_active;
    logic       acp_err;
    logic       trig_overrun;

    radar_sync_rx #(
        .ACP_PER_REV(ACP),
        .RANGE_BINS (BINS),
        .CLK_PER_BIN(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arp          (arp),
        .acp          (acp),
        .trig         (trig),
        .azimuth      (azimuth),
        .az_valid     (az_valid),
        .sweep_azimuth(sweep_azimuth),
        .range_bin    (range_bin),
        .bin_strobe   (bin_strobe),
        .sweep_active (sweep_active),
        .acp_err      (acp_err),
        .trig_overrun (trig_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        bit         ovr;
        logic [3:0] az;
    } sweep_t;

    sweep_t sweep_q[$];
    int     az_q[$];
    int     err_q[$];

    // Reference model: azimuth, ACPs since ARP, lock flag.
    int model_az     = 0;
    int model_cnt    = 0;
    bit model_locked = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor state.
    int     anchor    = 0;
    int     k         = 0;
    int     az_prev   = 0;
    int     stray     = 0;
    bit     active    = 1'b0;
    bit     pend_drop = 1'b0;
    bit     sa_prev   = 1'b0;
    bit     ovr_prev  = 1'b0;
    bit     err_prev  = 1'b0;
    sweep_t s;

    // Monitor: pop and compare whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            active = 0; k = 0; pend_drop = 0; sa_prev = 0;
            ovr_prev = 0; err_prev = 0; az_prev = 0;
        end else begin
            if (int'(azimuth) != az_prev) begin
                if (az_q.size() == 0) check("az_unexpected", int'(azimuth), az_prev);
                else check("azimuth", int'(azimuth), az_q.pop_front());
                az_prev = int'(azimuth);
            end
            if (acp_err) begin
                check("acp_err_width", int'(err_prev), 0);
                if (err_q.size() == 0) check("acp_err_unexpected", int'(acp_err), 0);
                else check("acp_err_azimuth", int'(azimuth), err_q.pop_front());
            end
            err_prev = acp_err;
            if (trig_overrun) begin
                check("overrun_width", int'(ovr_prev), 0);
                if (sweep_q.size() == 0) begin
                    check("overrun_unexpected", int'(trig_overrun), 0);
                end else begin
                    s = sweep_q.pop_front();
                    check("overrun_kind", int'(trig_overrun), int'(s.ovr));
                    check("sweep_az_reload", int'(sweep_azimuth), int'(s.az));
                    check("active_in_overrun", int'(sweep_active), 1);
                end
                anchor = cyc; k = 0; active = 1; pend_drop = 0;
            end else if (sweep_active && !sa_prev) begin
                if (sweep_q.size() == 0) begin
                    check("sweep_unexpected", int'(sweep_active), 0);
                end else begin
                    s = sweep_q.pop_front();
                    check("sweep_start_kind", int'(trig_overrun), int'(s.ovr));
                    check("sweep_azimuth", int'(sweep_azimuth), int'(s.az));
                end
                anchor = cyc; k = 0; active = 1;
            end
            if (pend_drop) begin
                check("sweep_active_drop", int'(sweep_active), 0);
                pend_drop = 0;
            end
            if (bin_strobe) begin
                if (!active) begin
                    stray++;
                    check("stray_strobe", int'(bin_strobe), 0);
                end else begin
                    check("range_bin", int'(range_bin), k);
                    check("strobe_time", cyc - anchor, CPB * k + CPB - 1);
                    check("active_at_strobe", int'(sweep_active), 1);
                    k++;
                    if (k == BINS) begin
                        active = 0;
                        pend_drop = 1;
                    end
                end
            end
            sa_prev  = sweep_active;
            ovr_prev = trig_overrun;
        end
    end

    task automatic pulse(input bit a_arp, input bit a_acp, input bit a_trig);
        @(negedge clk);
        arp = a_arp; acp = a_acp; trig = a_trig;
        repeat (3) @(negedge clk);
        arp = 1'b0; acp = 1'b0; trig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic issue_acp();
        model_az = (model_az + 1) % ACP;
        model_cnt++;
        az_q.push_back(model_az);
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic issue_arp(input bit with_acp);
        if (model_locked && model_cnt != ACP) err_q.push_back(0);
        if (model_az != 0) az_q.push_back(0);
        model_az = 0;
        model_cnt = 0;
        model_locked = 1'b1;
        pulse(1'b1, with_acp, 1'b0);
        check("az_valid", int'(az_valid), int'(model_locked));
    endtask

    task automatic issue_trig(input bit ovr);
        sweep_t e;
        e.ovr = ovr;
        e.az = 4'(model_az);
        sweep_q.push_back(e);
        pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (!sweep_active) idle = 1'b1;
        end
        check("wait_idle_timeout", int'(idle), 1);
    endtask

    task automatic wait_strobe(input int bin);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bin_strobe && int'(range_bin) == bin) seen = 1'b1;
        end
        check("wait_strobe_timeout", int'(seen), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_azimuth"}, int'(azimuth), 0);
        check({tag, "_az_valid"}, int'(az_valid), 0);
        check({tag, "_sweep_azimuth"}, int'(sweep_azimuth), 0);
        check({tag, "_range_bin"}, int'(range_bin), 0);
        check({tag, "_bin_strobe"}, int'(bin_strobe), 0);
        check({tag, "_sweep_active"}, int'(sweep_active), 0);
        check({tag, "_acp_err"}, int'(acp_err), 0);
        check({tag, "_trig_overrun"}, int'(trig_overrun), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int stray_before;
        rst = 1'b0; arp = 1'b0; acp = 1'b0; trig = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Sweep accepted while unlocked.
        issue_trig(1'b0);
        wait_idle();
        check("az_valid_unlocked", int'(az_valid), 0);

        // Full revolution: no error.
        issue_arp(1'b0);
        for (int i = 0; i < ACP; i++) issue_acp();
        issue_arp(1'b0);

        // Short revolution: one error.
        for (int i = 0; i < ACP - 1; i++) issue_acp();
        issue_arp(1'b0);

        // Coincident ARP and ACP at azimuth 7, then a clean revolution.
        for (int i = 0; i < 7; i++) issue_acp();
        issue_arp(1'b1);
        for (int i = 0; i < ACP; i++) issue_acp();
        issue_arp(1'b0);

        // Sweep at azimuth 5 with an overrun trig landing in bin 3.
        for (int i = 0; i < 5; i++) issue_acp();
        issue_trig(1'b0);
        wait_strobe(2);
        issue_trig(1'b1);
        issue_acp();
        wait_idle();

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            int r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) issue_acp();
            end else if (r == 6) begin
                issue_arp(1'b0);
            end else if (r == 7) begin
                issue_arp(1'b1);
            end else begin
                wait_idle();
                issue_trig(1'b0);
            end
        end

        // Reset in the middle of bin 4 with pins held high across release.
        wait_idle();
        issue_trig(1'b0);
        wait_strobe(4);
        #2;
        rst = 1'b0;
        sweep_q.delete(); az_q.delete(); err_q.delete();
        model_az = 0; model_cnt = 0; model_locked = 1'b0;
        #1;
        check_all_zero("async_reset");
        acp = 1'b1; trig = 1'b1;
        repeat (3) @(negedge clk);
        stray_before = stray;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        acp = 1'b0; trig = 1'b0;
        repeat (20) @(negedge clk);
        check("no_strobe_after_reset", stray - stray_before, 0);
        check("no_sweep_after_reset", int'(sweep_active), 0);
        check("azimuth_after_reset", int'(azimuth), 0);
        check("unlocked_after_reset", int'(az_valid), 0);

        issue_trig(1'b0);
        wait_idle();
        repeat (10) @(negedge clk);
        check("sweep_q_left", sweep_q.size(), 0);
        check("az_q_left", az_q.size(), 0);
        check("err_q_left", err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
